// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS subset core: datapath plus control FSM behind one shared, handshaked
// instruction/data memory port. Illegal opcodes/functs and misaligned lw/sw park the core in TRAP.
module mips_multicycle_datapath #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       PC,
    output logic              instr_done,
    output logic              trap,
    output logic [2:0]        state_o,
    input  logic [4:0]        dbg_raddr,
    output logic [31:0]       dbg_rdata
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    state_t             state;
    logic [31:0]        pc;
    logic [31:0]        ir;
    logic [31:0]        alu_out;
    logic [31:0]        mdr;
    logic signed [31:0] a_q;
    logic signed [31:0] b_q;
    logic [31:0]        rf [32];

    logic [5:0]         op;
    logic [5:0]         funct;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic signed [31:0] simm;
    logic [31:0]        br_off;
    logic               is_rtype, is_lw, is_sw, is_beq, is_addi, is_j;
    logic               funct_ok;
    logic               legal;
    logic signed [31:0] exec_res;
    logic [31:0]        jump_pc;
    logic [31:0]        exec_pc;
    logic [4:0]         wb_idx;
    logic [31:0]        wb_data;

    function automatic logic signed [31:0] alu(
        input logic [5:0]         fn,
        input logic signed [31:0] x,
        input logic signed [31:0] y
    );
        case (fn)
            FN_SUB:  return x - y;
            FN_AND:  return x & y;
            FN_OR:   return x | y;
            FN_SLT:  return (x < y) ? 32'sd1 : 32'sd0;
            default: return x + y;
        endcase
    endfunction

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign simm   = {{16{ir[15]}}, ir[15:0]};
    assign br_off = {simm[29:0], 2'b00};

    assign is_rtype = (op == OP_RTYPE);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_addi  = (op == OP_ADDI);
    assign is_j     = (op == OP_J);

    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT);
    assign legal    = is_rtype ? funct_ok : (is_lw | is_sw | is_beq | is_addi | is_j);

    // lw/sw effective address shares the adder path with addi
    assign exec_res = is_rtype ? alu(funct, a_q, b_q) : (a_q + simm);
    assign jump_pc  = {pc[31:28], ir[25:0], 2'b00};
    assign exec_pc  = is_j ? jump_pc : ((a_q == b_q) ? alu_out : pc);

    assign wb_idx  = is_rtype ? rd : rt;
    assign wb_data = is_lw ? mdr : alu_out;

    // sw retires in the cycle its write is accepted, so this pulse cannot be registered
    assign instr_done = (state == S_WB) ||
                        ((state == S_EXEC) && (is_beq || is_j)) ||
                        ((state == S_MEM) && is_sw && mem_ready);

    assign PC        = pc;
    assign state_o   = state;
    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : rf[dbg_raddr];

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            trap      <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    mem_re   <= 1'b1;
                    mem_addr <= pc[ADDR_W-1:0];
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir     <= mem_rdata;
                        pc     <= pc + 32'd4;
                        mem_re <= 1'b0;
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rf[rs];
                    b_q     <= rf[rt];
                    alu_out <= pc + br_off;
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_beq || is_j) begin
                        pc       <= exec_pc;
                        mem_addr <= exec_pc[ADDR_W-1:0];
                        mem_re   <= 1'b1;
                        state    <= S_FETCH;
                    end else if (is_lw || is_sw) begin
                        alu_out <= exec_res;
                        if (exec_res[1:0] != 2'b00) begin
                            state <= S_TRAP;
                            trap  <= 1'b1;
                        end else begin
                            mem_addr  <= exec_res[ADDR_W-1:0];
                            mem_re    <= is_lw;
                            mem_we    <= is_sw;
                            mem_wdata <= b_q;
                            state     <= S_MEM;
                        end
                    end else begin
                        alu_out <= exec_res;
                        state   <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_lw) begin
                            mdr    <= mem_rdata;
                            mem_re <= 1'b0;
                            state  <= S_WB;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_re   <= 1'b1;
                            mem_addr <= pc[ADDR_W-1:0];
                            state    <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (wb_idx != 5'd0) begin
                        rf[wb_idx] <= wb_data;
                    end
                    mem_re   <= 1'b1;
                    mem_addr <= pc[ADDR_W-1:0];
                    state    <= S_FETCH;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state  <= S_TRAP;
                    trap   <= 1'b1;
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Bench for mips_multicycle_datapath: random legal programs against an instruction-level
// reference model, plus directed reset, handshake, branch and trap scenarios.
`timescale 1ns/1ps
module tb_mips_multicycle_datapath;

    localparam int          AW  = 16;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic          CLK       = 1'b0;
    logic          rst       = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic [31:0]   PC;
    logic          instr_done;
    logic          trap;
    logic [2:0]    state_o;
    logic [4:0]    dbg_raddr = '0;
    logic [31:0]   dbg_rdata;

    mips_multicycle_datapath #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .PC         (PC),
        .instr_done (instr_done),
        .trap       (trap),
        .state_o    (state_o),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 CLK = ~CLK;

    int          n_vec      = 0;
    int          n_err      = 0;
    int          force_wait = -1;
    int          wait_left  = -1;
    int          we_cycles  = 0;
    logic [31:0] bmem    [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ref_r   [32];
    logic [31:0] ref_pc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put(input int idx, input logic [31:0] val);
        bmem[idx]    = val;
        ref_mem[idx] = val;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) put(i, 32'd0);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    function automatic logic [31:0] rand_instr(input int w);
        logic [5:0]  fns [5];
        logic [4:0]  s, t, d;
        int          k, tgt;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
        k = $urandom_range(0, 99);
        s = 5'($urandom_range(0, 31));
        t = 5'($urandom_range(0, 31));
        d = 5'($urandom_range(0, 31));
        if (d == 5'd29) d = 5'd0;
        if (k < 35) return enc_r(s, t, d, fns[$urandom_range(0, 4)]);
        if (k < 55) return enc_i(6'h08, s, d, 16'($urandom));
        if (k < 70) return enc_i(6'h23, 5'd29, d, 16'(32'h100 + 4 * $urandom_range(0, 63)));
        if (k < 85) return enc_i(6'h2B, 5'd29, t, 16'(32'h100 + 4 * $urandom_range(0, 63)));
        tgt = $urandom_range(64, 191);
        if (k < 95) return enc_i(6'h04, s, ($urandom_range(0, 1) == 1) ? s : t, 16'(tgt - w - 1));
        return {6'h02, 26'(tgt)};
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_pc", PC, RPC);
        chk("rst_strobes", {28'd0, mem_re, mem_we, trap, instr_done}, 32'd0);
        @(negedge CLK);
        rst = 1'b1;
        #1;
        chk("idle_state", 32'(state_o), 32'd0);
        chk("idle_re", 32'(mem_re), 32'd0);
        @(negedge CLK);
        chk("fetch_state", 32'(state_o), 32'd1);
        chk("fetch_re", 32'(mem_re), 32'd1);
        chk("fetch_addr", 32'(mem_addr), RPC & 32'h0000_FFFF);
        ref_pc = RPC;
        for (int i = 0; i < 32; i++) ref_r[i] = 32'd0;
        wait_left  = -1;
        force_wait = -1;
    endtask

    // Executes one instruction in the model and follows the DUT through it from its first fetch cycle.
    task automatic run_one();
        logic [31:0] ins, simm, pc4, ea, av, bv, res, npc;
        logic [31:0] e_addr [2];
        logic [31:0] e_data [2];
        logic        e_we [2];
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, wr_idx;
        logic        exp_trap, wr_en, st_en, done, prev_stall, p_re, p_we, quiet;
        logic [AW-1:0] p_addr;
        logic [31:0] p_wdata;
        int          base, trap_at, n_exp, acc_idx, stalls, cyc;

        ins  = ref_mem[ref_pc[9:2]];
        op   = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
        simm = {{16{ins[15]}}, ins[15:0]};
        pc4  = ref_pc + 32'd4;
        av   = ref_r[rs];
        bv   = ref_r[rt];
        exp_trap = 1'b0; wr_en = 1'b0; st_en = 1'b0; wr_idx = 5'd0; res = 32'd0; ea = 32'd0;
        n_exp = 1; e_we[0] = 1'b0; e_addr[0] = ref_pc; e_data[0] = 32'd0;
        e_we[1] = 1'b0; e_addr[1] = 32'd0; e_data[1] = 32'd0;
        npc = pc4; base = 4; trap_at = 0;
        case (op)
            6'h00: begin
                wr_en = 1'b1; wr_idx = rd;
                case (fn)
                    6'h20: res = av + bv;
                    6'h22: res = av - bv;
                    6'h24: res = av & bv;
                    6'h25: res = av | bv;
                    6'h2A: res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
                    default: begin exp_trap = 1'b1; trap_at = 2; wr_en = 1'b0; end
                endcase
            end
            6'h08: begin wr_en = 1'b1; wr_idx = rt; res = av + simm; end
            6'h23, 6'h2B: begin
                ea = av + simm;
                if (ea[1:0] != 2'b00) begin
                    exp_trap = 1'b1; trap_at = 3;
                end else begin
                    n_exp = 2; e_addr[1] = ea; e_we[1] = (op == 6'h2B); e_data[1] = bv;
                    if (op == 6'h23) begin
                        base = 5; wr_en = 1'b1; wr_idx = rt; res = ref_mem[ea[9:2]];
                    end else begin
                        st_en = 1'b1;
                    end
                end
            end
            6'h04: begin base = 3; if (av == bv) npc = pc4 + (simm << 2); end
            6'h02: begin base = 3; npc = {pc4[31:28], ins[25:0], 2'b00}; end
            default: begin exp_trap = 1'b1; trap_at = 2; end
        endcase

        chk("start_pc", PC, ref_pc);
        acc_idx = 0; stalls = 0; cyc = 0; done = 1'b0; prev_stall = 1'b0; we_cycles = 0;
        p_re = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        while (!done) begin
            if (prev_stall) begin
                chk("hold_addr", 32'(mem_addr), 32'(p_addr));
                chk("hold_strobes", {30'd0, mem_re, mem_we}, {30'd0, p_re, p_we});
                if (p_we) chk("hold_wdata", mem_wdata, p_wdata);
            end
            chk("re_we_excl", 32'(mem_re & mem_we), 32'd0);
            if (mem_we) we_cycles++;
            if (mem_re || mem_we) begin
                if (wait_left < 0) wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = bmem[mem_addr[9:2]];
                    if (acc_idx < n_exp) begin
                        chk("acc_we", 32'(mem_we), 32'(e_we[acc_idx]));
                        chk("acc_addr", 32'(mem_addr), e_addr[acc_idx] & 32'h0000_FFFF);
                        if (e_we[acc_idx]) chk("acc_wdata", mem_wdata, e_data[acc_idx]);
                    end else begin
                        chk("acc_extra", 32'(acc_idx), 32'(n_exp));
                    end
                    if (mem_we) bmem[mem_addr[9:2]] = mem_wdata;
                    acc_idx++;
                    wait_left  = -1;
                    prev_stall = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    wait_left--;
                    stalls++;
                    prev_stall = 1'b1;
                    p_addr = mem_addr; p_wdata = mem_wdata; p_re = mem_re; p_we = mem_we;
                end
            end else begin
                mem_ready  = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                prev_stall = 1'b0;
            end
            #1;
            if (instr_done || trap || cyc >= 60) begin
                done = 1'b1;
            end else begin
                @(negedge CLK);
                cyc++;
            end
        end

        if (exp_trap) begin
            chk("trap_flag", 32'(trap), 32'd1);
            chk("trap_cycle", 32'(cyc), 32'(trap_at + stalls));
            chk("trap_state", 32'(state_o), 32'd7);
            chk("trap_pc", PC, pc4);
            quiet = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge CLK);
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                if (mem_re || mem_we || instr_done || !trap || state_o != 3'd7) quiet = 1'b0;
            end
            chk("trap_quiet", 32'(quiet), 32'd1);
        end else begin
            chk("retired", 32'(instr_done), 32'd1);
            chk("latency", 32'(cyc + 1), 32'(base + stalls));
            chk("acc_count", 32'(acc_idx), 32'(n_exp));
            if (wr_en && wr_idx != 5'd0) ref_r[wr_idx] = res;
            if (st_en) ref_mem[ea[9:2]] = bv;
            ref_pc = npc;
            @(negedge CLK);
        end
    endtask

    task automatic dump_regs();
        mem_ready = 1'b0;
        for (int r = 0; r < 32; r++) begin
            dbg_raddr = 5'(r);
            #1;
            chk($sformatf("reg%0d", r), dbg_rdata, ref_r[r]);
        end
    endtask

    task automatic dbg_chk(input string tag, input logic [4:0] r, input logic [31:0] exp);
        dbg_raddr = r;
        #1;
        chk(tag, dbg_rdata, exp);
    endtask

    initial begin
        int sw_we, ndiff, seen;

        // random legal programs against the reference model
        clear_mem();
        for (int i = 192; i < 256; i++) put(i, $urandom);
        put(64, enc_i(6'h08, 5'd0, 5'd29, 16'h0200));
        for (int w = 65; w < 191; w++) put(w, rand_instr(w));
        put(191, {6'h02, 26'd64});
        do_reset();
        for (int n = 0; n < 400; n++) run_one();
        dump_regs();
        ndiff = 0;
        for (int i = 0; i < 256; i++) if (bmem[i] !== ref_mem[i]) ndiff++;
        chk("mem_image", 32'(ndiff), 32'd0);

        // directed arithmetic, memory wait, $0 write, branches and jump, then illegal opcode
        clear_mem();
        put(64, 32'h2008_0005);
        put(65, 32'h0108_4820);
        put(66, 32'hAC08_0008);
        put(67, 32'h8C0A_0008);
        put(68, 32'h2000_0007);
        put(69, 32'h1108_0002);
        put(70, 32'h200B_0001);
        put(71, 32'h200B_0001);
        put(72, 32'h1100_0002);
        put(73, {6'h02, 26'd76});
        put(74, 32'h200C_0001);
        put(75, 32'h200C_0001);
        put(76, 32'hFC00_0000);
        do_reset();
        run_one();
        run_one();
        force_wait = 3;
        run_one();
        sw_we = we_cycles;
        run_one();
        force_wait = -1;
        for (int n = 0; n < 4; n++) run_one();
        chk("sw_we_cycles", 32'(sw_we), 32'd4);
        chk("sw_mem", bmem[2], 32'd5);
        dump_regs();
        dbg_chk("r9_add", 5'd9, 32'd10);
        dbg_chk("r10_lw", 5'd10, 32'd5);
        dbg_chk("r0_zero", 5'd0, 32'd0);
        dbg_chk("r11_skipped", 5'd11, 32'd0);
        dbg_chk("r12_skipped", 5'd12, 32'd0);
        @(negedge CLK);
        run_one();

        // misaligned lw traps from EXEC
        clear_mem();
        put(64, 32'h8C01_0001);
        do_reset();
        run_one();

        // reset in the middle of a stalled store
        clear_mem();
        put(64, 32'h2008_0005);
        put(65, 32'hAC08_0008);
        do_reset();
        run_one();
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            if (mem_we) begin
                seen++;
                mem_ready = 1'b0;
            end else begin
                mem_ready = mem_re;
                mem_rdata = bmem[mem_addr[9:2]];
            end
            if (seen < 2) @(negedge CLK);
        end
        chk("store_wait_seen", 32'(seen), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_pc", PC, RPC);
        dbg_chk("abort_r8", 5'd8, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
